// File: rtl/mau_ahb_lsq.sv
// mau_ahb_lsq: load/store queue for the data side of the core. EXU requests
// are buffered in a DEPTH-entry FIFO and issued as pipelined AHB-Lite SINGLE
// transfers to the DTCM. Load results are lane-extracted, sign- or zero-extended
// and returned on the writeback port.
//
// Ports:
//   hclk, hrst                 clock, asynchronous active-high reset
//   req_*                      EXU request (valid/ready), store data LSB-aligned
//   flush                      drop queued requests that have not been issued yet
//   haddr..hwdata, hready,
//   hresp, hrdata              AHB-Lite master interface
//   wb_valid, wb_rd, wb_data   load writeback pulse
//   err_*                      bus-error / misalignment pulse
//   busy                       queue non-empty or data phase outstanding
module mau_ahb_lsq #(
    parameter int          DATA_W    = 32,
    parameter int          ADDR_W    = 32,
    parameter int          DEPTH     = 4,
    parameter logic [3:0]  HPROT_VAL = 4'b0011
) (
    input  logic              hclk,
    input  logic              hrst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_sext,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    input  logic              flush,
    output logic [ADDR_W-1:0] haddr,
    output logic [1:0]        htrans,
    output logic              hwrite,
    output logic [2:0]        hsize,
    output logic [2:0]        hburst,
    output logic [3:0]        hprot,
    output logic              hmastlock,
    output logic [DATA_W-1:0] hwdata,
    input  logic              hready,
    input  logic              hresp,
    input  logic [DATA_W-1:0] hrdata,
    output logic              wb_valid,
    output logic [4:0]        wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              err_valid,
    output logic [ADDR_W-1:0] err_addr,
    output logic              err_store,
    output logic              err_misalign,
    output logic              busy
);

    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;
    localparam int LANE_W = $clog2(DATA_W / 8);

    logic [ADDR_W-1:0] q_addr  [DEPTH];
    logic [DATA_W-1:0] q_wdata [DEPTH];
    logic [1:0]        q_size  [DEPTH];
    logic              q_write [DEPTH];
    logic              q_sext  [DEPTH];
    logic [4:0]        q_rd    [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;

    logic              dp_valid, dp_write, dp_sext;
    logic [1:0]        dp_size;
    logic [ADDR_W-1:0] dp_addr;
    logic [DATA_W-1:0] dp_wdata;
    logic [4:0]        dp_rd;

    logic              head_valid, head_misalign, full;
    logic [ADDR_W-1:0] head_addr;
    logic [1:0]        head_size;
    logic              head_write;
    logic              issue, addr_accept, mis_pop, push, pop;
    logic              dp_done, bus_err_done, load_done;
    logic [DATA_W-1:0] st_repl, ld_shift, ld_ext;

    assign hburst    = 3'b000;
    assign hprot     = HPROT_VAL;
    assign hmastlock = 1'b0;

    assign full       = (count == CW'(DEPTH));
    assign head_valid = (count != '0);
    assign head_addr  = q_addr[rd_ptr];
    assign head_size  = q_size[rd_ptr];
    assign head_write = q_write[rd_ptr];

    always_comb begin
        head_misalign = 1'b0;
        case (head_size)
            2'd0: head_misalign = 1'b0;
            2'd1: head_misalign = head_addr[0];
            2'd2: head_misalign = |head_addr[1:0];
            default: head_misalign = (|head_addr[2:0]) || (DATA_W == 32);
        endcase
    end

    // A pending error response blocks the next address phase (AHB two-cycle error).
    assign issue        = head_valid && !head_misalign && !flush && !(dp_valid && hresp);
    assign addr_accept  = issue && hready;
    assign dp_done      = dp_valid && hready;
    assign bus_err_done = dp_done && hresp;
    assign load_done    = dp_done && !hresp && !dp_write;
    // A misaligned head waits one cycle if a bus error is reported this cycle.
    assign mis_pop      = head_valid && head_misalign && !flush && !bus_err_done;

    assign req_ready = !hrst && !full && !flush;
    assign push      = req_valid && req_ready;
    assign pop       = addr_accept || mis_pop;

    assign htrans = issue ? 2'b10 : 2'b00;
    assign haddr  = head_valid ? head_addr : '0;
    assign hsize  = head_valid ? {1'b0, head_size} : 3'b000;
    assign hwrite = head_valid ? head_write : 1'b0;
    assign hwdata = dp_wdata;
    assign busy   = head_valid || dp_valid;

    always_comb begin
        st_repl = q_wdata[rd_ptr];
        case (head_size)
            2'd0: st_repl = {(DATA_W/8){q_wdata[rd_ptr][7:0]}};
            2'd1: st_repl = {(DATA_W/16){q_wdata[rd_ptr][15:0]}};
            2'd2: st_repl = {(DATA_W/32){q_wdata[rd_ptr][31:0]}};
            default: st_repl = q_wdata[rd_ptr];
        endcase
    end

    always_comb begin
        logic sign;
        int   nbits;
        ld_shift = hrdata >> {dp_addr[LANE_W-1:0], 3'b000};
        ld_ext   = ld_shift;
        sign     = 1'b0;
        nbits    = DATA_W;
        case (dp_size)
            2'd0: begin sign = ld_shift[7];  nbits = 8;  end
            2'd1: begin sign = ld_shift[15]; nbits = 16; end
            2'd2: begin sign = ld_shift[31]; nbits = 32; end
            default: begin sign = ld_shift[DATA_W-1]; nbits = DATA_W; end
        endcase
        for (int i = 0; i < DATA_W; i++) begin
            if (i >= nbits) ld_ext[i] = dp_sext & sign;
        end
    end

    always_ff @(posedge hclk) begin
        if (push) begin
            q_addr[wr_ptr]  <= req_addr;
            q_wdata[wr_ptr] <= req_wdata;
            q_size[wr_ptr]  <= req_size;
            q_write[wr_ptr] <= req_write;
            q_sext[wr_ptr]  <= req_sext;
            q_rd[wr_ptr]    <= req_rd;
        end
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_sext  <= 1'b0;
            dp_size  <= '0;
            dp_addr  <= '0;
            dp_wdata <= '0;
            dp_rd    <= '0;
        end else if (addr_accept) begin
            dp_valid <= 1'b1;
            dp_write <= head_write;
            dp_sext  <= q_sext[rd_ptr];
            dp_size  <= head_size;
            dp_addr  <= head_addr;
            dp_wdata <= st_repl;
            dp_rd    <= q_rd[rd_ptr];
        end else if (dp_done) begin
            dp_valid <= 1'b0;
        end
    end

    always_ff @(posedge hclk or posedge hrst) begin
        if (hrst) begin
            wb_valid     <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            err_valid    <= 1'b0;
            err_addr     <= '0;
            err_store    <= 1'b0;
            err_misalign <= 1'b0;
        end else begin
            wb_valid  <= load_done;
            err_valid <= bus_err_done || mis_pop;
            if (load_done) begin
                wb_rd   <= dp_rd;
                wb_data <= ld_ext;
            end
            if (bus_err_done) begin
                err_addr     <= dp_addr;
                err_store    <= dp_write;
                err_misalign <= 1'b0;
            end else if (mis_pop) begin
                err_addr     <= head_addr;
                err_store    <= head_write;
                err_misalign <= 1'b1;
            end
        end
    end

endmodule
